// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath write enables,
// the mux selects and the immediate format select. It also owns the request
// handshake on the shared memory port and a watchdog that traps when a request
// stays unanswered for too long. Control outputs are decoded from the state
// register and from the opcode latched in DECODE.
module multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  input  logic             br_taken_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_addr_sel_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic [2:0]       imm_sel_o,
  output logic             alu_src_a_o,
  output logic             alu_src_b_o,
  output logic             rf_we_o,
  output logic [1:0]       wb_sel_o,
  output logic             illegal_o,
  output logic             mem_timeout_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  // Watchdog counter wide enough to hold MEM_TIMEOUT.
  localparam int unsigned      TO_W    = $clog2(MEM_TIMEOUT + 1);
  // Count value meaning "this wait cycle is the MEM_TIMEOUT-th one".
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  // RV32I base opcodes handled by this core.
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              illegal_q;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  retired_q;

  logic              illegal_set_s;
  logic              timeout_set_s;
  logic              retire_s;

  logic              mem_req_s;
  logic              mem_we_s;
  logic              mem_addr_sel_s;
  logic              ir_we_s;
  logic              pc_we_s;
  logic [1:0]        pc_src_s;
  logic [2:0]        imm_sel_s;
  logic              alu_src_a_s;
  logic              alu_src_b_s;
  logic              rf_we_s;
  logic [1:0]        wb_sel_s;

  // Only the opcode field of the IR matters to the controller.
  logic              unused_instr_s;
  assign unused_instr_s = ^instr_i[31:7];

  // True for the nine opcodes this core executes.
  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Immediate format for an opcode; R-type and unknown opcodes use 0.
  function automatic logic [2:0] op_imm_sel(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: sel = IMM_I;
      OPC_STORE:                      sel = IMM_S;
      OPC_BRANCH:                     sel = IMM_B;
      OPC_LUI, OPC_AUIPC:             sel = IMM_U;
      OPC_JAL:                        sel = IMM_J;
      default:                        sel = IMM_I;
    endcase
    return sel;
  endfunction

  // Next-state, watchdog and control-output decode.
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    to_cnt_d       = '0;
    illegal_set_s  = 1'b0;
    timeout_set_s  = 1'b0;
    retire_s       = 1'b0;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_sel_s = 1'b0;
    ir_we_s        = 1'b0;
    pc_we_s        = 1'b0;
    pc_src_s       = PC_PLUS4;
    imm_sel_s      = IMM_I;
    alu_src_a_s    = 1'b0;
    alu_src_b_s    = 1'b0;
    rf_we_s        = 1'b0;
    wb_sel_s       = WB_ALU;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b0;
        if (mem_ready_i) begin
          // IR captures read data and PC advances on the handshake cycle.
          ir_we_s  = 1'b1;
          pc_we_s  = 1'b1;
          pc_src_s = PC_PLUS4;
          state_d  = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set_s = 1'b1;
          state_d       = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DECODE: begin
        opcode_d  = instr_i[6:0];
        imm_sel_s = op_imm_sel(instr_i[6:0]);
        if (op_legal(instr_i[6:0])) begin
          state_d = S_EXEC;
        end else begin
          illegal_set_s = 1'b1;
          state_d       = S_TRAP;
        end
      end

      S_EXEC: begin
        imm_sel_s = op_imm_sel(opcode_q);
        case (opcode_q)
          OPC_OP: begin
            state_d = S_WB;
          end
          OPC_OP_IMM: begin
            alu_src_b_s = 1'b1;
            state_d     = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b_s = 1'b1;
            state_d     = S_MEM;
          end
          OPC_AUIPC: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 1'b1;
            state_d     = S_WB;
          end
          OPC_LUI: begin
            state_d = S_WB;
          end
          OPC_BRANCH: begin
            // Branch retires here: no memory or writeback phase.
            pc_we_s  = br_taken_i;
            pc_src_s = PC_REL;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end
          OPC_JAL: begin
            pc_we_s  = 1'b1;
            pc_src_s = PC_REL;
            state_d  = S_WB;
          end
          OPC_JALR: begin
            pc_we_s  = 1'b1;
            pc_src_s = PC_JALR;
            state_d  = S_WB;
          end
          default: begin
            // Unreachable: DECODE only admits legal opcodes.
            state_d = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_we_s       = (opcode_q == OPC_STORE);
        imm_sel_s      = op_imm_sel(opcode_q);
        if (mem_ready_i) begin
          if (opcode_q == OPC_STORE) begin
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_set_s = 1'b1;
          state_d       = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_WB: begin
        rf_we_s   = 1'b1;
        imm_sel_s = op_imm_sel(opcode_q);
        case (opcode_q)
          OPC_LOAD:          wb_sel_s = WB_MEM;
          OPC_JAL, OPC_JALR: wb_sel_s = WB_LINK;
          OPC_LUI:           wb_sel_s = WB_IMM;
          default:           wb_sel_s = WB_ALU;
        endcase
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // State, opcode, watchdog, sticky flags and retire counter; sync reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      opcode_q      <= 7'h00;
      to_cnt_q      <= '0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      to_cnt_q      <= to_cnt_d;
      illegal_q     <= illegal_q | illegal_set_s;
      mem_timeout_q <= mem_timeout_q | timeout_set_s;
      if (retire_s) begin
        retired_q <= retired_q + CNT_W'(1);
      end else begin
        retired_q <= retired_q;
      end
    end
  end

  assign mem_req_o      = mem_req_s;
  assign mem_we_o       = mem_we_s;
  assign mem_addr_sel_o = mem_addr_sel_s;
  assign ir_we_o        = ir_we_s;
  assign pc_we_o        = pc_we_s;
  assign pc_src_o       = pc_src_s;
  assign imm_sel_o      = imm_sel_s;
  assign alu_src_a_o    = alu_src_a_s;
  assign alu_src_b_o    = alu_src_b_s;
  assign rf_we_o        = rf_we_s;
  assign wb_sel_o       = wb_sel_s;
  assign illegal_o      = illegal_q;
  assign mem_timeout_o  = mem_timeout_q;
  assign state_o        = state_q;
  assign retired_o      = retired_q;

endmodule
